// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: state width, byte layout and the ShiftRows
// byte-index helper used by both the encrypt and decrypt row-rotation stages.
package aes_pkg;

  localparam int DATA_WIDTH = 128;
  localparam int BYTE_WIDTH = 8;
  localparam int NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH;
  localparam int NUM_ROWS   = 4;
  localparam int NUM_COLS   = 4;

  // Byte k (k = 4*col + row) lives at packed index NUM_BYTES-1-k, i.e. bits [127-8k -: 8].
  typedef logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0] state_t;

  // Source byte index feeding output byte (col, row). Encrypt rotates row r left
  // by r; the inverse rotates it right by r.
  function automatic int unsigned shift_row_src(input int unsigned col,
                                                input int unsigned row,
                                                input logic        inverse);
    int unsigned src_col;
    if (inverse) src_col = (col + NUM_COLS - row) % NUM_COLS;
    else         src_col = (col + row) % NUM_COLS;
    return NUM_ROWS * src_col + row;
  endfunction

endpackage

// File: rtl/inv_shift_row_perm.sv
// Purely combinational AES inverse ShiftRows byte permutation on a 128-bit state.
module inv_shift_row_perm
  import aes_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data
);

  state_t in_s;
  state_t out_s;

  assign in_s = in_data;

  always_comb begin
    out_s = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        out_s[NUM_BYTES-1-(NUM_ROWS*c+r)] = in_s[NUM_BYTES-1-int'(shift_row_src(c, r, 1'b1))];
      end
    end
  end

  assign out_data = out_s;

endmodule

// File: rtl/inv_shift_row.sv
// Inverse ShiftRows stage with a 2-entry output buffer and accepted-block counter.
// Define INV_SHIFT_ROW_BYPASS_EN to add a bypass input that stores blocks unpermuted.
module inv_shift_row
  import aes_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
`ifdef INV_SHIFT_ROW_BYPASS_EN
  input  logic                  bypass,
`endif
  output logic [CNT_WIDTH-1:0]  blk_count
);

  localparam int DEPTH = 2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic [CNT_WIDTH-1:0]  blk_count_q, blk_count_d;

  logic [DATA_WIDTH-1:0] perm_data;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  push;
  logic                  pop;

  inv_shift_row_perm u_perm (
    .in_data  (in_data),
    .out_data (perm_data)
  );

`ifdef INV_SHIFT_ROW_BYPASS_EN
  assign wr_data = bypass ? in_data : perm_data;
`else
  assign wr_data = perm_data;
`endif

  // Handshake outputs come only from registered state, never from out_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign blk_count = blk_count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // NOTE: every signal written here gets its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    blk_count_d = blk_count_q;

    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = ~wr_ptr_q;
      blk_count_d     = blk_count_q + CNT_WIDTH'(1);
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the two storage entries are reset too, so out_data reads zero from reset rather than X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      blk_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of its peers.
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      blk_count_q <= blk_count_d;
    end
  end

endmodule

// File: doc/inv_shift_row.md
# inv_shift_row

Inverse ShiftRows stage for the AES decrypt datapath, the decrypt-side counterpart of the encrypt ShiftRow step. It accepts a 128-bit state over a valid/ready handshake and applies the inverse row rotation. The result is held in a 2-entry output buffer, so downstream backpressure never drops a block. It sits between the inverse-round key-add/InvMixColumns output and InvSubBytes in each decrypt round.

## Interface
- DATA_WIDTH, 128, state width; fixed at 128.
- CNT_WIDTH, 16, width of the accepted-block counter.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input state valid.
- in_ready  out  1  stage can accept; high when the buffer holds fewer than 2 entries.
- in_data  in  DATA_WIDTH  input state; byte k occupies bits [127-8k -: 8]; column-major, k = 4*col + row.
- out_valid  out  1  buffer non-empty.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  head-of-buffer state.
- blk_count  out  CNT_WIDTH  number of blocks accepted since reset, mod 2^CNT_WIDTH.
- bypass  in  1  present only with INV_SHIFT_ROW_BYPASS_EN; see Configuration.

## Operation
- Permutation: out byte (4c+r) = in byte (4*((c-r) mod 4) + r). Row r rotates right by r; row 0 is unchanged.
- Push occurs when in_valid && in_ready. The permuted state is written at the tail, the tail pointer increments mod 2, and blk_count increments, wrapping 0xFFFF -> 0x0000.
- Pop occurs when out_valid && out_ready. The head pointer increments mod 2.
- Occupancy count ranges 0..2:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged, both pointers advance.
- Full (count = 2): in_ready low, so no push. A pop in that cycle frees a slot; in_ready rises the following cycle.
- Empty (count = 0): out_valid low; out_ready is ignored.
- in_data is a don't-care when in_valid is low; nothing is stored.
- Reset asserted mid-operation discards all buffered blocks immediately (asynchronous). Any partially completed handshake is lost.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, out_data = 0, blk_count = 0.
  - Pointers and count = 0; both storage entries = 0.
- Latency: a block pushed on rising edge N appears on out_data with out_valid high after edge N (visible in cycle N+1).
- Throughput: 1 block/cycle while out_ready is held high.
- in_ready depends only on registered count, never combinationally on out_ready.
- out_data and out_valid are driven from registers and the head pointer only; there is no combinational path from the input side.
- out_data holds stable while out_valid && !out_ready.

## Configuration
- INV_SHIFT_ROW_BYPASS_EN defined:
  - The bypass input port exists.
  - When bypass is high at a push, in_data is stored unpermuted. This is used for test paths and key-schedule passthrough.
  - blk_count still increments on such a push.
- Not defined:
  - The port is absent and every push is permuted.
  - Behaviour is otherwise identical.

## Structure
- Shared package aes_pkg holds:
  - DATA_WIDTH and the byte-width constant.
  - The state typedef (16 x 8-bit array).
  - The byte-index helper function shared with the encrypt ShiftRow.
- Sub-module inv_shift_row_perm: purely combinational 128-bit inverse permutation, instantiated once on the write path.
- The buffer, pointers, count and counter live in the top module.

## Test plan
- Reset, then push 0x000102030405060708090a0b0c0d0e0f with out_ready=1:
  - out_valid high the next cycle with out_data = 0x000d0a0704010e0b0805020f0c090603.
  - blk_count = 1.
- Round trip: feed this stage's output through encrypt ShiftRow for 11 vectors:
  - each result equals the original input.
- Backpressure: out_ready=0, push 3 consecutive blocks A, B, C:
  - A and B are accepted; in_ready goes low after the second push; C is held.
  - Raise out_ready: outputs A, B, C in order with no loss or duplication.
- Simultaneous push/pop at count = 1 for 10 cycles:
  - count stays 1; outputs emerge one per cycle in order; blk_count advances by 10.
- Counter wrap:
  - push 65536 blocks: blk_count returns to 0x0000.
  - Mid-stream, drive rst low with 2 entries buffered: out_valid = 0, in_ready = 1 and blk_count = 0 immediately.
- With INV_SHIFT_ROW_BYPASS_EN, bypass=1, push the same vector:
  - out_data = 0x000102030405060708090a0b0c0d0e0f.
